// File: rtl/csd_scan_ctrl_pkg.sv
// Shared types and constants for the CSD scan controller and its datapath.
package csd_pkg;

   // Controller sequencing states.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      INIT = 3'd1,
      READ = 3'd2,
      EVAL = 3'd3,
      FIN  = 3'd4
   } csd_state_t;

   // Digit memory geometry and the value being counted.
   localparam int         CSD_DEPTH    = 16;
   localparam int         CSD_LAST_IDX = 15;
   localparam logic [7:0] CSD_ONE      = 8'h01;

endpackage

// File: rtl/csd_scan_ctrl_if.sv
// Control/status bundle between the scan controller and the CSD datapath.
//
// Strobe semantics: every control strobe is a single-cycle, level-sampled
// command that the datapath acts on at the next rising clock edge whenever it
// is high; there is no back-pressure, so the datapath must accept every strobe.
// Zi and Zcsd are level status flags produced by the datapath and sampled by
// the controller on the same rising edge.
interface csd_scan_ctrl_if;

   logic start;    // 0: host address drives memory, 1: index i drives memory
   logic weCsd;    // memory write enable
   logic reCsd;    // memory read enable (dataOut valid one cycle later)
   logic Load;     // clear index counter i
   logic enable;   // increment index counter i
   logic loadCnt;  // clear hit counter cnti
   logic enCnt;    // increment hit counter cnti
   logic Zi;       // high while i < last index
   logic Zcsd;     // high when dataOut equals the counted value

   // Controller side.
   modport master (
      output start, weCsd, reCsd, Load, enable, loadCnt, enCnt,
      input  Zi, Zcsd
   );

   // Datapath side.
   modport slave (
      input  start, weCsd, reCsd, Load, enable, loadCnt, enCnt,
      output Zi, Zcsd
   );

endinterface

// File: rtl/csd_scan_ctrl.sv
// Scan controller: lends the digit memory to the host while idle, then on a
// go request walks all entries through the datapath and counts 8'h01 hits.
module csd_scan_ctrl
   import csd_pkg::*;
#(
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               reset,      // asynchronous, active low
   input  logic               go,
   input  logic               abort,
   input  logic               host_we,
   csd_scan_ctrl_if.master    dp,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [CNT_W-1:0]   hit_count,
   output csd_state_t         dbg_state
);

   localparam logic [CNT_W-1:0] HIT_MAX = CNT_W'(CSD_DEPTH);
   localparam logic [CNT_W-1:0] HIT_ONE = CNT_W'(1);

   csd_state_t       state_q, state_d;
   logic [CNT_W-1:0] hit_q, hit_d;
   logic             aborted_q, aborted_d;
   logic             cancel;

   // Abort is honoured only in the scanning states; FIN always completes.
   assign cancel = abort && (state_q == INIT || state_q == READ || state_q == EVAL);

   // Next-state selection and abort pulse request.
   always_comb begin
      state_d   = state_q;
      aborted_d = 1'b0;
      case (state_q)
         IDLE: if (go) state_d = INIT;
         INIT: state_d = READ;
         READ: state_d = EVAL;
         EVAL: state_d = dp.Zi ? READ : FIN;
         FIN:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (cancel) begin
         state_d   = IDLE;
         aborted_d = 1'b1;
      end
   end

   // Hit counter: cleared on scan start, bumped on a matching entry, saturating.
   always_comb begin
      hit_d = hit_q;
      if (state_q == INIT) begin
         hit_d = '0;
      end else if (state_q == EVAL && dp.Zcsd && !abort && hit_q < HIT_MAX) begin
         hit_d = hit_q + HIT_ONE;
      end
   end

   // State, hit count and abort pulse registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         hit_q     <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hit_q     <= hit_d;
         aborted_q <= aborted_d;
      end
   end

   // Output decode: Moore strobes per state, plus the qualified EVAL strobes
   // and the host write pass-through in IDLE (held off while reset is low).
   always_comb begin
      dp.start   = 1'b0;
      dp.weCsd   = 1'b0;
      dp.reCsd   = 1'b0;
      dp.Load    = 1'b0;
      dp.enable  = 1'b0;
      dp.loadCnt = 1'b0;
      dp.enCnt   = 1'b0;
      done       = 1'b0;
      case (state_q)
         IDLE: dp.weCsd = host_we && reset;
         INIT: begin
            dp.start   = 1'b1;
            dp.Load    = 1'b1;
            dp.loadCnt = 1'b1;
         end
         READ: begin
            dp.start = 1'b1;
            dp.reCsd = 1'b1;
         end
         EVAL: begin
            dp.start  = 1'b1;
            dp.enable = dp.Zi && !abort;
            dp.enCnt  = dp.Zcsd && !abort;
         end
         FIN: begin
            dp.start = 1'b1;
            done     = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign aborted   = aborted_q;
   assign hit_count = hit_q;
   assign dbg_state = state_q;

   // The hit count can never exceed the number of memory entries.
   hit_count_bounded: assert property (@(posedge clk) disable iff (!reset)
      hit_q <= HIT_MAX);

endmodule

// File: doc/csd_scan_ctrl.md
# csd_scan_ctrl

Sequencing controller for the CSD conversion datapath. Hands the digit memory to the host for loading while idle. On a `go` pulse it takes ownership, walks all 16 memory entries through the datapath's index counter, and counts entries equal to 8'h01 (`Zcsd`) in both its own register and the datapath's `cnti` counter. It then reports completion to the host. It sits beside the datapath and drives all of its control inputs.

## Interface
Parameters:
- `CNT_W`, 5: width of `hit_count`; must hold 0..16.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `go`  in  1  scan request; sampled only in IDLE.
- `abort`  in  1  synchronous scan cancel; sampled only while busy.
- `host_we`  in  1  host memory-write request; forwarded only in IDLE.
- `Zi`  in  1  from datapath, high while index `i` < 15.
- `Zcsd`  in  1  from datapath, high when `dataOut` == 8'h01.
- `start`  out  1  datapath address select: 0 selects the host address, 1 selects `i`.
- `weCsd`  out  1  memory write enable.
- `reCsd`  out  1  memory read enable.
- `Load`  out  1  clears the index counter `i` to 0.
- `enable`  out  1  increments `i`.
- `loadCnt`  out  1  clears the hit counter `cnti` to 0.
- `enCnt`  out  1  increments `cnti`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a scan completes.
- `aborted`  out  1  one-cycle pulse when a scan is cancelled.
- `hit_count`  out  CNT_W  number of 8'h01 entries found in the last scan.

## Operation
- States: IDLE, INIT, READ, EVAL, FIN.
- IDLE
  - `start`=0.
  - `weCsd`=`host_we`, combinational pass-through.
  - All other strobes are 0.
  - `go`=1 moves to INIT.
- INIT
  - `start`=1, `Load`=1, `loadCnt`=1.
  - `hit_count` clears to 0.
  - Next state is READ.
- READ
  - `start`=1, `reCsd`=1.
  - Memory reads are synchronous with a 1-cycle latency, so `dataOut`, and therefore `Zcsd`, is valid in the following EVAL cycle.
  - Next state is EVAL.
- EVAL
  - `start`=1.
  - If `Zcsd`=1: `enCnt`=1 and `hit_count` increments.
  - If `Zi`=1: `enable`=1 and the next state is READ.
  - If `Zi`=0: the next state is FIN; this is the last entry, `i`=15.
- FIN
  - `start`=1.
  - `done`=1 for one cycle.
  - Next state is IDLE.
- `weCsd` is 0 in every non-IDLE state. `host_we` asserted while busy is dropped, not queued.
- `go` outside IDLE is ignored.
- `abort`=1 in INIT, READ or EVAL:
  - next state is IDLE, and `aborted`=1 in that IDLE cycle;
  - `done` is not asserted;
  - `hit_count` holds its partial value;
  - no `enable`/`enCnt` is issued in the abort cycle.
- Simultaneous `abort` and `Zi`=0 in EVAL: `abort` wins.
- `abort` in FIN is ignored.
- `hit_count` saturates at 16. Never exceeding 16 is a checked assertion.

## Timing
- Reset values (reset=0, asynchronous):
  - state IDLE;
  - `hit_count`=0;
  - `busy`, `done`, `aborted` = 0;
  - all datapath strobes 0;
  - `start`=0.
- Strobes are Moore outputs of the state, except:
  - `weCsd` in IDLE, which follows `host_we`;
  - `enable`/`enCnt` in EVAL, which are qualified by `Zi`/`Zcsd`/`abort`.
- Latency, with `go` sampled at edge 0:
  - INIT in cycle 1;
  - entry k: READ in cycle 2+2k, EVAL in cycle 3+2k;
  - FIN in cycle 34, so `done` is high 34 cycles after the `go` edge.
- Throughput: the earliest next `go` is accepted in the first IDLE cycle after FIN, giving 35 cycles per scan.
- `busy` rises one cycle after `go` and falls in the same cycle that `done` is sampled low again, i.e. on entry to IDLE.
- Reset asserted mid-scan: immediate return to IDLE, `hit_count`=0, no `done`/`aborted` pulse.

## Structure
- Shared package `csd_pkg` holds:
  - state enum `csd_state_t` {IDLE, INIT, READ, EVAL, FIN};
  - constants `CSD_DEPTH`=16, `CSD_LAST_IDX`=15, `CSD_ONE`=8'h01.
- Single module; no sub-module. Contents:
  - next-state logic;
  - registered state;
  - the `hit_count` register with saturation;
  - an output decode block.

## Test plan
- Reset then idle with `host_we`=1: `weCsd`=1, `start`=0, `busy`=0; during reset all outputs are 0.
- Memory preloaded with 8'h01 at addresses 0, 5, 15; `go` pulse → `done` exactly 34 cycles later, `hit_count`=3, datapath `cnti`=3, 16 `reCsd` pulses.
- All 16 entries 8'h01 → `hit_count`=16. All entries 8'h00 → `hit_count`=0 and `enCnt` never asserted.
- `abort` in the EVAL of entry 7, with entries 0 and 3 = 8'h01 → `aborted` pulse, no `done`, `hit_count`=2, `busy`=0 next cycle.
- `go` and `host_we` asserted while busy → ignored: `weCsd` stays 0, a single `done`, no second scan.
- Reset deasserted→asserted in cycle 20 of a scan → immediate IDLE, `hit_count`=0. A subsequent `go` completes a normal scan.
